// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-serial load/store controller between the load buffer/ROB and a byte-wide RAM
`timescale 1ns/1ps
module data_mem_ctrl #(
  parameter int ROB_WIDTH       = 4,
  parameter int INST_TYPE_WIDTH = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       rob_flush_in,
  input  logic                       ram_bus_en_in,
  input  logic [31:0]                ram_bus_A_in,
  input  logic [ROB_WIDTH-1:0]       ram_bus_dest_in,
  input  logic [INST_TYPE_WIDTH-1:0] ram_bus_inst_type_in,
  output logic                       ram_bus_rdy_out,
  output logic                       ram_bus_data_en_out,
  output logic [31:0]                ram_bus_data_out,
  output logic [ROB_WIDTH-1:0]       ram_bus_dest_out,
  input  logic                       store_en_in,
  input  logic [31:0]                store_A_in,
  input  logic [31:0]                store_data_in,
  input  logic [INST_TYPE_WIDTH-1:0] store_type_in,
  output logic                       store_done_out,
  input  logic [7:0]                 mem_din_in,
  output logic [7:0]                 mem_dout_out,
  output logic [31:0]                mem_a_out,
  output logic                       mem_wr_out
);

  localparam logic [INST_TYPE_WIDTH-1:0] T_LB  = INST_TYPE_WIDTH'(0);
  localparam logic [INST_TYPE_WIDTH-1:0] T_LH  = INST_TYPE_WIDTH'(1);
  localparam logic [INST_TYPE_WIDTH-1:0] T_LW  = INST_TYPE_WIDTH'(2);
  localparam logic [INST_TYPE_WIDTH-1:0] T_LBU = INST_TYPE_WIDTH'(3);
  localparam logic [INST_TYPE_WIDTH-1:0] T_LHU = INST_TYPE_WIDTH'(4);
  localparam logic [INST_TYPE_WIDTH-1:0] T_SB  = INST_TYPE_WIDTH'(5);
  localparam logic [INST_TYPE_WIDTH-1:0] T_SH  = INST_TYPE_WIDTH'(6);
  localparam logic [INST_TYPE_WIDTH-1:0] T_SW  = INST_TYPE_WIDTH'(7);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_DONE} state_t;

  function automatic logic [2:0] f_size(input logic [INST_TYPE_WIDTH-1:0] t);
    case (t)
      T_LB, T_LBU, T_SB: f_size = 3'd1;
      T_LH, T_LHU, T_SH: f_size = 3'd2;
      default:           f_size = 3'd4;
    endcase
  endfunction

  state_t                     r_state;
  logic [2:0]                 r_cyc;
  logic [2:0]                 r_n;
  logic [31:0]                r_addr;
  logic [31:0]                r_sdata;
  logic [31:0]                r_buf;
  logic [INST_TYPE_WIDTH-1:0] r_type;
  logic [ROB_WIDTH-1:0]       r_dest;
  logic [31:0]                r_mem_a;
  logic [7:0]                 r_mem_dout;
  logic                       r_mem_wr;
  logic                       r_data_en;
  logic [31:0]                r_data;
  logic [ROB_WIDTH-1:0]       r_dest_out;
  logic                       r_store_done;

  logic                       w_idle_ok;
  logic                       w_accept_st;
  logic                       w_accept_ld;
  logic [2:0]                 w_st_n;
  logic [2:0]                 w_ld_n;
  logic [1:0]                 w_byte_idx;
  logic [7:0]                 w_next_byte;
  logic [31:0]                w_full;
  logic [31:0]                w_ext;

  assign w_idle_ok   = (r_state == S_IDLE) && !rob_flush_in;
  assign w_accept_st = w_idle_ok && store_en_in;
  assign w_accept_ld = w_idle_ok && !store_en_in && ram_bus_en_in;
  assign w_st_n      = f_size(store_type_in);
  assign w_ld_n      = f_size(ram_bus_inst_type_in);
  assign w_byte_idx  = r_cyc[1:0] + 2'd1;
  assign w_next_byte = r_sdata[{w_byte_idx, 3'b000} +: 8];

  // RAM data lags its address by one cycle, so in LOAD cycle r_cyc the bus carries byte r_cyc-1.
  always_comb begin
    w_full = r_buf;
    case (r_cyc)
      3'd1:    w_full[7:0]   = mem_din_in;
      3'd2:    w_full[15:8]  = mem_din_in;
      3'd3:    w_full[23:16] = mem_din_in;
      3'd4:    w_full[31:24] = mem_din_in;
      default: w_full = r_buf;
    endcase
  end

  always_comb begin
    w_ext = w_full;
    case (r_type)
      T_LB:    w_ext = {{24{w_full[7]}}, w_full[7:0]};
      T_LH:    w_ext = {{16{w_full[15]}}, w_full[15:0]};
      T_LBU:   w_ext = {24'd0, w_full[7:0]};
      T_LHU:   w_ext = {16'd0, w_full[15:0]};
      T_LW:    w_ext = w_full;
      default: w_ext = w_full;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= S_IDLE;
      r_cyc        <= 3'd0;
      r_n          <= 3'd0;
      r_addr       <= 32'd0;
      r_sdata      <= 32'd0;
      r_buf        <= 32'd0;
      r_type       <= '0;
      r_dest       <= '0;
      r_mem_a      <= 32'd0;
      r_mem_dout   <= 8'd0;
      r_mem_wr     <= 1'b0;
      r_data_en    <= 1'b0;
      r_data       <= 32'd0;
      r_dest_out   <= '0;
      r_store_done <= 1'b0;
    end else if (rdy_in) begin
      r_data_en    <= 1'b0;
      r_store_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept_st) begin
            r_state      <= S_STORE;
            r_addr       <= store_A_in;
            r_sdata      <= store_data_in;
            r_type       <= store_type_in;
            r_n          <= w_st_n;
            r_cyc        <= 3'd0;
            r_mem_a      <= store_A_in;
            r_mem_dout   <= store_data_in[7:0];
            r_mem_wr     <= 1'b1;
            r_store_done <= (w_st_n == 3'd1);
          end else if (w_accept_ld) begin
            r_state  <= S_LOAD;
            r_addr   <= ram_bus_A_in;
            r_type   <= ram_bus_inst_type_in;
            r_dest   <= ram_bus_dest_in;
            r_n      <= w_ld_n;
            r_cyc    <= 3'd0;
            r_buf    <= 32'd0;
            r_mem_a  <= ram_bus_A_in;
            r_mem_wr <= 1'b0;
          end
        end
        S_LOAD: begin
          if (rob_flush_in) begin
            r_state <= S_IDLE;
            r_cyc   <= 3'd0;
          end else begin
            if (r_cyc != 3'd0) r_buf <= w_full;
            if (r_cyc == r_n) begin
              r_state    <= S_IDLE;
              r_cyc      <= 3'd0;
              r_data_en  <= 1'b1;
              r_data     <= w_ext;
              r_dest_out <= r_dest;
            end else begin
              r_cyc <= r_cyc + 3'd1;
              if (r_cyc + 3'd1 < r_n) r_mem_a <= r_addr + 32'(r_cyc) + 32'd1;
            end
          end
        end
        S_STORE: begin
          if (r_cyc + 3'd1 == r_n) begin
            r_state  <= S_DONE;
            r_cyc    <= 3'd0;
            r_mem_wr <= 1'b0;
          end else begin
            r_cyc        <= r_cyc + 3'd1;
            r_mem_a      <= r_addr + 32'(r_cyc) + 32'd1;
            r_mem_dout   <= w_next_byte;
            r_store_done <= (r_cyc + 3'd2 == r_n);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ram_bus_rdy_out     = (r_state == S_IDLE) && !rst_in && !rob_flush_in;
  assign ram_bus_data_en_out = r_data_en;
  assign ram_bus_data_out    = r_data;
  assign ram_bus_dest_out    = r_dest_out;
  assign store_done_out      = r_store_done;
  assign mem_a_out           = r_mem_a;
  assign mem_dout_out        = r_mem_dout;
  assign mem_wr_out          = r_mem_wr && rdy_in;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl
`timescale 1ns/1ps
module tb_data_mem_ctrl;

  localparam logic [3:0] LB = 4'd0, LH = 4'd1, LW = 4'd2, LBU = 4'd3, LHU = 4'd4;
  localparam logic [3:0] SB = 4'd5, SH = 4'd6, SW = 4'd7;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        ld_en, st_en;
  logic [31:0] ld_a, st_a, st_d;
  logic [3:0]  ld_tag, ld_typ, st_typ;
  logic        rdy_out, data_en, store_done, mem_wr;
  logic [31:0] data_out, mem_a;
  logic [3:0]  dest_out;
  logic [7:0]  mem_dout, mem_din;

  logic        pre_we;
  logic [11:0] pre_a;
  logic [7:0]  pre_d;

  bit   [7:0]  ram    [4096];
  bit          ram_wr [4096];
  logic [7:0]  mdl    [4096];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ROB_WIDTH(4), .INST_TYPE_WIDTH(4)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rob_flush_in(flush),
    .ram_bus_en_in(ld_en), .ram_bus_A_in(ld_a), .ram_bus_dest_in(ld_tag),
    .ram_bus_inst_type_in(ld_typ), .ram_bus_rdy_out(rdy_out),
    .ram_bus_data_en_out(data_en), .ram_bus_data_out(data_out),
    .ram_bus_dest_out(dest_out), .store_en_in(st_en), .store_A_in(st_a),
    .store_data_in(st_d), .store_type_in(st_typ), .store_done_out(store_done),
    .mem_din_in(mem_din), .mem_dout_out(mem_dout), .mem_a_out(mem_a),
    .mem_wr_out(mem_wr)
  );

  function automatic logic [7:0] dflt(input logic [11:0] a);
    int v;
    v = int'(a) * 37 + 11;
    return v[7:0];
  endfunction

  function automatic logic [7:0] env_rd(input logic [11:0] a);
    return ram_wr[a] ? ram[a] : dflt(a);
  endfunction

  // RAM sits behind the same global enable, so its read register freezes with rdy low.
  always @(posedge clk) begin
    if (pre_we) begin
      ram[pre_a]    <= pre_d;
      ram_wr[pre_a] <= 1'b1;
    end else if (mem_wr) begin
      ram[mem_a[11:0]]    <= mem_dout;
      ram_wr[mem_a[11:0]] <= 1'b1;
    end
    if (rdy) mem_din <= env_rd(mem_a[11:0]);
  end

  function automatic int tsize(input logic [3:0] t);
    if (t == LB || t == LBU || t == SB) return 1;
    if (t == LH || t == LHU || t == SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] t, input logic [31:0] a);
    logic [31:0] v = 32'd0;
    logic [31:0] ak;
    for (int k = 0; k < tsize(t); k++) begin
      ak = a + 32'(k);
      v  = v + (32'(mdl[ak[11:0]]) << (8 * k));
    end
    if (t == LB && v >= 32'd128)   v = v - 32'd256;
    if (t == LH && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  task automatic model_store(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ak;
    for (int k = 0; k < tsize(t); k++) begin
      ak = a + 32'(k);
      mdl[ak[11:0]] = 8'(d >> (8 * k));
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    mdl[a] = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic run_op(input bit st, input logic [3:0] t, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] tag,
                        input logic [31:0] exp, input int flush_at);
    int n = tsize(t);
    @(posedge clk); #1;
    if (st) begin st_en = 1'b1; st_a = a; st_d = d; st_typ = t; end
    else begin ld_en = 1'b1; ld_a = a; ld_tag = tag; ld_typ = t; end
    @(negedge clk);
    chk("rdy_before_accept", 32'(rdy_out), 32'd1);
    @(posedge clk); #1;
    st_en = 1'b0; ld_en = 1'b0;
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      if (st) begin
        chk("st_wr", 32'(mem_wr), 32'(c <= n));
        if (c <= n) begin
          chk("st_addr", mem_a, a + 32'(c - 1));
          chk("st_byte", 32'(mem_dout), (d >> (8 * (c - 1))) & 32'hFF);
        end
        chk("st_done", 32'(store_done), 32'(c == n));
      end else begin
        chk("ld_wr", 32'(mem_wr), 32'd0);
        if (c <= n) chk("ld_addr", mem_a, a + 32'(c - 1));
        chk("ld_data_en", 32'(data_en), 32'(c == n + 2));
        if (c == n + 2) begin
          chk("ld_data", data_out, exp);
          chk("ld_dest", 32'(dest_out), 32'(tag));
        end
      end
      chk("rdy_out", 32'(rdy_out), 32'(c == n + 2));
      flush = (c == flush_at);
    end
    flush = 1'b0;
    if (st) model_store(t, a, d);
  endtask

  typedef struct {
    bit          st;
    logic [3:0]  typ;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  tag;
    logic [31:0] exp;
    int          fl;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, LB,  32'h0000_0100, 32'h0,         4'd3, 32'hFFFF_FF80, 0};
    tbl[1]  = '{1'b0, LBU, 32'h0000_0100, 32'h0,         4'd1, 32'h0000_0080, 0};
    tbl[2]  = '{1'b0, LW,  32'h0000_0200, 32'h0,         4'd5, 32'h4433_2211, 0};
    tbl[3]  = '{1'b0, LH,  32'h0000_0400, 32'h0,         4'd2, 32'hFFFF_9C00, 0};
    tbl[4]  = '{1'b0, LHU, 32'h0000_0400, 32'h0,         4'd4, 32'h0000_9C00, 0};
    tbl[5]  = '{1'b1, SH,  32'h0000_0300, 32'hABCD_1234, 4'd0, 32'h0,         0};
    tbl[6]  = '{1'b1, SB,  32'h0000_0302, 32'h0000_00F0, 4'd0, 32'h0,         0};
    tbl[7]  = '{1'b0, LW,  32'h0000_0300, 32'h0,         4'd6, 32'h5EF0_1234, 0};
    tbl[8]  = '{1'b1, SW,  32'hFFFF_FFFE, 32'hCAFE_F00D, 4'd0, 32'h0,         0};
    tbl[9]  = '{1'b0, LW,  32'hFFFF_FFFE, 32'h0,         4'd7, 32'hCAFE_F00D, 0};
    tbl[10] = '{1'b1, SW,  32'h0000_0310, 32'h89AB_CDEF, 4'd0, 32'h0,         2};
    tbl[11] = '{1'b0, LW,  32'h0000_0310, 32'h0,         4'd8, 32'h89AB_CDEF, 0};
    tbl[12] = '{1'b0, LH,  32'h0000_0200, 32'h0,         4'd9, 32'h0000_2211, 0};

    for (int i = 0; i < 4096; i++) mdl[i] = dflt(12'(i));
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; ld_en = 1'b0; st_en = 1'b0;
    ld_a = 0; st_a = 0; st_d = 0; ld_tag = 0; ld_typ = 0; st_typ = 0;
    pre_we = 1'b0; pre_a = 0; pre_d = 0;
    @(posedge clk); #1;
    preload(12'h100, 8'h80);
    preload(12'h200, 8'h11); preload(12'h201, 8'h22);
    preload(12'h202, 8'h33); preload(12'h203, 8'h44);
    preload(12'h400, 8'h00); preload(12'h401, 8'h9C);
    preload(12'h303, 8'h5E);

    @(negedge clk);
    chk("rst_rdy_out", 32'(rdy_out), 32'd0);
    chk("rst_data_en", 32'(data_en), 32'd0);
    chk("rst_store_done", 32'(store_done), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_dest", 32'(dest_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy_out", 32'(rdy_out), 32'd1);

    for (int i = 0; i < 13; i++)
      run_op(tbl[i].st, tbl[i].typ, tbl[i].a, tbl[i].d, tbl[i].tag, tbl[i].exp, tbl[i].fl);

    // store and load in the same idle cycle: store wins, load held until accepted
    @(posedge clk); #1;
    st_en = 1'b1; st_a = 32'h500; st_d = 32'h0000_003C; st_typ = SB;
    ld_en = 1'b1; ld_a = 32'h500; ld_tag = 4'hA; ld_typ = LBU;
    @(posedge clk); #1;
    st_en = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("prio_wr", 32'(mem_wr), 32'(c == 1));
      chk("prio_rdy", 32'(rdy_out), 32'(c == 3));
      if (c < 3) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    ld_en = 1'b0;
    model_store(SB, 32'h500, 32'h3C);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("prio_ld_data_en", 32'(data_en), 32'(c == 3));
      if (c == 3) begin
        chk("prio_ld_data", data_out, 32'h0000_003C);
        chk("prio_ld_dest", 32'(dest_out), 32'hA);
      end
    end

    // flush aborts an in-flight LHU
    @(posedge clk); #1;
    ld_en = 1'b1; ld_a = 32'h400; ld_tag = 4'hB; ld_typ = LHU;
    @(posedge clk); #1;
    ld_en = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      flush = (c == 2);
      @(negedge clk);
      chk("flush_ld_data_en", 32'(data_en), 32'd0);
      chk("flush_ld_wr", 32'(mem_wr), 32'd0);
      if (c == 3) chk("flush_ld_rdy", 32'(rdy_out), 32'd1);
      @(posedge clk); #1;
    end
    flush = 1'b0;

    // flush in the same cycle as a load request
    ld_en = 1'b1; ld_a = 32'h200; ld_tag = 4'hC; ld_typ = LW; flush = 1'b1;
    @(negedge clk);
    chk("flush_req_rdy", 32'(rdy_out), 32'd0);
    @(posedge clk); #1;
    ld_en = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_req_still_idle", 32'(rdy_out), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("flush_req_no_data_en", 32'(data_en), 32'd0);
    end

    // rdy_in low for two cycles mid-LW
    @(posedge clk); #1;
    ld_en = 1'b1; ld_a = 32'h200; ld_tag = 4'hC; ld_typ = LW;
    @(posedge clk); #1;
    ld_en = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      logic [31:0] ea;
      rdy = !(c == 2 || c == 3);
      @(negedge clk);
      case (c)
        1: ea = 32'h200;
        2, 3, 4: ea = 32'h201;
        5: ea = 32'h202;
        default: ea = 32'h203;
      endcase
      if (c <= 6) chk("stall_addr", mem_a, ea);
      chk("stall_wr", 32'(mem_wr), 32'd0);
      chk("stall_data_en", 32'(data_en), 32'(c == 8));
      if (c == 8) chk("stall_data", data_out, 32'h4433_2211);
      @(posedge clk); #1;
    end
    rdy = 1'b1;

    // reset in the middle of a load drops it silently
    ld_en = 1'b1; ld_a = 32'h200; ld_tag = 4'hD; ld_typ = LW;
    @(posedge clk); #1;
    ld_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("midrst_mem_a", mem_a, 32'd0);
    chk("midrst_rdy", 32'(rdy_out), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("midrst_no_data_en", 32'(data_en), 32'd0);
    end

    for (int i = 0; i < 30; i++) begin
      bit          st;
      logic [3:0]  t;
      logic [31:0] a, d;
      logic [3:0]  tag;
      st  = bit'($urandom_range(0, 1));
      a   = 32'h1800 + 32'($urandom_range(0, 12));
      d   = $urandom;
      tag = 4'($urandom_range(0, 15));
      if (st) begin
        case ($urandom_range(0, 2))
          0: t = SB;
          1: t = SH;
          default: t = SW;
        endcase
        run_op(1'b1, t, a, d, 4'd0, 32'd0, 0);
      end else begin
        case ($urandom_range(0, 4))
          0: t = LB;
          1: t = LH;
          2: t = LW;
          3: t = LBU;
          default: t = LHU;
        endcase
        run_op(1'b0, t, a, 32'd0, tag, model_load(t, a), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
